led_pwm_driver: RTL and testbench
=================================

Name: led_pwm_driver

Overview:
- Downstream consumer of the user-logic core on the Nano 9K board top. Replaces the direct bit-to-LED assignment with per-LED 8-bit PWM brightness.
- Accepts duty-cycle writes over a valid/ready handshake into per-channel shadow registers.
- Commits shadow values glitch-free at PWM period boundaries.
- Drives the board's active-low LED pins from registered outputs.

Parameters:
- N_LED, 6: number of LED channels (1..8).
- PRESCALE, 105: clock cycles per PWM tick (>=1). 27 MHz / 105 / 256 gives about 1 kHz.
- ACTIVE_LOW, 1: 1 means an LED is lit when its pin is 0.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  synchronous reset, active-high.
- i_valid  input  1  duty write request.
- o_ready  output  1  block can accept a write.
- i_chan  input  3  target channel index.
- i_duty  input  8  duty value, 0..255.
- o_led  output  N_LED  LED pins, polarity per ACTIVE_LOW.
- o_period_start  output  1  one-cycle pulse at each PWM period start.
- o_err  output  1  one-cycle pulse when a write targets i_chan >= N_LED.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset state, for any cycle with i_reset=1:
  - all shadow and active duties = 0;
  - prescaler = 0, pwm_cnt = 0;
  - o_led = all-off level (all 1s when ACTIVE_LOW=1);
  - o_ready = 0, o_period_start = 0, o_err = 0.
- Reset mid-period aborts the period immediately; no partial state survives.
- o_ready: registered. It goes to 1 on the first clock edge after i_reset deasserts and then stays 1. The handshake never stalls; the port exists for upstream protocol compliance.
- Write accept:
  - Occurs on a cycle with i_valid & o_ready.
  - If i_chan < N_LED, shadow[i_chan] <= i_duty.
  - Otherwise the write is dropped and o_err=1 on the next cycle.
  - Multiple writes to the same channel within one period: last write wins.
- Prescaler: counts 0..PRESCALE-1. tick=1 in the cycle where count = PRESCALE-1, after which the count wraps to 0. PRESCALE=1 means tick on every cycle.
- pwm_cnt: 8-bit counter, increments on tick, wraps 255 -> 0. One period = 256*PRESCALE clocks.
- Commit:
  - Happens in the cycle where tick & pwm_cnt==255.
  - active[i] <= shadow[i] for all i.
  - A write accepted in that same cycle is included, i.e. active takes the new value (bypass).
- o_period_start: registered. It equals 1 during the first cycle in which pwm_cnt==0 after a wrap. It is not asserted after reset release; the first pulse comes at the first wrap.
- LED output:
  - Lit condition: lit[i] = (pwm_cnt < active[i]).
  - o_led[i] <= lit[i] XOR ACTIVE_LOW, registered, so one cycle of latency after pwm_cnt changes.
  - duty 0 means never lit; duty 255 means lit 255/256 of the period (never full-on).
- Write-to-visible latency: the new duty appears on o_led starting 1 clock after the first period start following the accept.
- Arithmetic: unsigned only. Comparison width is 8 bits. Prescaler width is $clog2(PRESCALE) (minimum 1).

Decomposition:
- Shared package led_pkg holds:
  - PWM_W=8;
  - default N_LED=6 and PRESCALE=105;
  - LED_OFF level for the Nano 9K (1'b1);
  - duty type (logic [PWM_W-1:0]).
- One sub-module, pwm_tick_gen: the prescaler, which outputs a one-cycle tick every PRESCALE clocks and resets synchronously.
- The compare, shadow and commit logic stays in led_pwm_driver.

Test Plan (bench uses PRESCALE=2, so period = 512 clocks):
- Reset: hold i_reset=1 for 3 cycles -> o_led=6'b111111 and o_ready=0 throughout; o_ready=1 one edge after release; first o_period_start 512 clocks after release.
- Single write: chan 0, duty 64 -> from the next period start, o_led[0]=0 for 128 clocks then 1 for 384 clocks, repeating; other LEDs stay 1.
- Extremes: chan1 duty 0 and chan2 duty 255 -> o_led[1]=1 constantly; o_led[2]=0 for 510 clocks and 1 for 2 clocks per period.
- Invalid channel: write i_chan=6, then i_chan=7 -> o_err pulses for one cycle after each; all o_led waveforms unchanged.
- Mid-period write and boundary bypass:
  - Write chan3 duty 128 at pwm_cnt=50 -> o_led[3] unchanged for the rest of that period; 256 clocks low from the next period.
  - Write chan4 duty 10 in the exact commit cycle -> takes effect in the immediately following period.
- Reset mid-operation: with duties 64/128 active, assert i_reset at pwm_cnt=100 -> o_led=all 1 on the next edge; after release all LEDs stay off (duties cleared) until rewritten.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the Nano 9K LED PWM driver.
// Board LEDs are active-low, so the default off level is a logic 1.
package led_pkg;

  localparam int PWM_W        = 8;
  localparam int N_LED_DEF    = 6;
  localparam int PRESCALE_DEF = 105;
  localparam bit LED_OFF      = 1'b1;

  typedef logic [PWM_W-1:0] duty_t;

  localparam duty_t PWM_LAST = '1;

  // Strict less-than keeps duty 0 fully dark and duty 255 short of full-on.
  function automatic logic duty_lit(input duty_t cnt, input duty_t duty);
    return cnt < duty;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler that divides the system clock down to the PWM tick rate.
// o_tick is high for one cycle every PRESCALE clocks (every cycle when PRESCALE=1).
module pwm_tick_gen #(
  parameter int PRESCALE = 105
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = w_last;

endmodule

// File: rtl/led_pwm_driver.sv
// Per-LED 8-bit PWM driver: duty writes land in shadow registers and are
// committed to the active set only at the period wrap, so waveforms never glitch.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int N_LED      = N_LED_DEF,
  parameter int PRESCALE   = PRESCALE_DEF,
  parameter bit ACTIVE_LOW = LED_OFF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_chan,
  input  logic [7:0]       i_duty,
  output logic [N_LED-1:0] o_led,
  output logic             o_period_start,
  output logic             o_err
);

  localparam logic [3:0] CHAN_LIM = 4'(N_LED);

  logic             w_tick;
  logic             w_accept;
  logic             w_chan_ok;
  logic             w_wr_ok;
  logic             w_commit;
  duty_t            w_shadow_nxt [N_LED];
  logic [N_LED-1:0] w_lit;

  logic             r_ready;
  logic             r_err;
  logic             r_period_start;
  duty_t            r_pwm_cnt;
  duty_t            r_shadow [N_LED];
  duty_t            r_active [N_LED];
  logic [N_LED-1:0] r_led;

  pwm_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (w_tick)
  );

  assign w_accept  = i_valid & r_ready;
  assign w_chan_ok = ({1'b0, i_chan} < CHAN_LIM);
  assign w_wr_ok   = w_accept & w_chan_ok;
  assign w_commit  = w_tick & (r_pwm_cnt == PWM_LAST);

  // Shadow next-state doubles as the commit source, so a write landing in the
  // commit cycle is picked up by the period that starts right after it.
  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      w_shadow_nxt[i] = r_shadow[i];
      if (w_wr_ok && (i_chan == 3'(i))) begin
        w_shadow_nxt[i] = i_duty;
      end
    end
  end

  // ---- stage 0: handshake, counters, shadow/active duty registers ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ready        <= 1'b0;
      r_err          <= 1'b0;
      r_period_start <= 1'b0;
      r_pwm_cnt      <= '0;
    end else begin
      r_ready        <= 1'b1;
      r_err          <= w_accept & ~w_chan_ok;
      r_period_start <= w_commit;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + duty_t'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N_LED; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        r_shadow[i] <= w_shadow_nxt[i];
        if (w_commit) begin
          r_active[i] <= w_shadow_nxt[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      w_lit[i] = duty_lit(r_pwm_cnt, r_active[i]);
    end
  end

  // ---- stage 1: registered pin drive with board polarity ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_led <= {N_LED{ACTIVE_LOW}};
    end else begin
      r_led <= w_lit ^ {N_LED{ACTIVE_LOW}};
    end
  end

  assign o_ready        = r_ready;
  assign o_err          = r_err;
  assign o_period_start = r_period_start;
  assign o_led          = r_led;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver at PRESCALE=2 (512-clock periods): directed writes
// queue the expected duty set per period; a monitor scores each period's waveform.
module tb_led_pwm_driver;

  localparam int NL  = 6;
  localparam int PS  = 2;
  localparam int PER = 256 * PS;

  typedef logic [NL-1:0][7:0] duty_vec_t;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_valid;
  logic          o_ready;
  logic [2:0]    i_chan;
  logic [7:0]    i_duty;
  logic [NL-1:0] o_led;
  logic          o_period_start;
  logic          o_err;

  int checks   = 0;
  int failures = 0;

  duty_vec_t exp_q[$];
  duty_vec_t v_exp;
  duty_vec_t cur;
  bit        win = 1'b0;
  int        k = 0;
  int        win_idx = 0;
  int        windows_done = 0;
  int        lit_a [NL];
  int        lit_e [NL];
  int        bad   [NL];
  int        n;

  led_pwm_driver #(
    .N_LED      (NL),
    .PRESCALE   (PS),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_chan         (i_chan),
    .i_duty         (i_duty),
    .o_led          (o_led),
    .o_period_start (o_period_start),
    .o_err          (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] ch, input logic [7:0] d);
    i_valid = 1'b1;
    i_chan  = ch;
    i_duty  = d;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_ps(output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (o_period_start) break;
      if (cycles > PER + 64) begin
        checks++;
        failures++;
        $display("FAIL wait_period_start actual=timeout after %0d cycles required=pulse", cycles);
        break;
      end
    end
  endtask

  task automatic close_window(input bit partial);
    for (int i = 0; i < NL; i++) begin
      checks++;
      if (bad[i] != 0) begin
        failures++;
        $display("FAIL window%0d%s led%0d lit_cycles=%0d expected_lit_cycles=%0d mismatched_cycles=%0d",
                 win_idx, partial ? "_partial" : "", i, lit_a[i], lit_e[i], bad[i]);
      end
    end
    windows_done++;
  endtask

  // Scoreboard monitor: each period start pops the duty set expected for that period.
  initial begin
    forever begin
      @(negedge clk);
      if (win && i_reset) begin
        close_window(1'b1);
        win = 1'b0;
      end else if (win) begin
        for (int i = 0; i < NL; i++) begin
          automatic bit a = (o_led[i] == 1'b0);
          automatic bit e = ((k / PS) < int'(cur[i]));
          lit_a[i] += int'(a);
          lit_e[i] += int'(e);
          if (a != e) bad[i]++;
        end
        k++;
        if (k == PER) begin
          close_window(1'b0);
          win = 1'b0;
        end
      end
      if (o_period_start && !i_reset && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        win = 1'b1;
        k = 0;
        win_idx++;
        for (int i = 0; i < NL; i++) begin
          lit_a[i] = 0;
          lit_e[i] = 0;
          bad[i]   = 0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_chan  = '0;
    i_duty  = '0;

    repeat (3) begin
      @(negedge clk);
      check("rst_led", 32'(o_led), 32'h3f);
      check("rst_ready", 32'(o_ready), 0);
      check("rst_period_start", 32'(o_period_start), 0);
      check("rst_err", 32'(o_err), 0);
    end

    v_exp = '0;
    exp_q.push_back(v_exp);
    i_reset = 1'b0;
    @(negedge clk);
    check("ready_after_release", 32'(o_ready), 1);
    check("led_off_after_release", 32'(o_led), 32'h3f);
    wait_ps(n);
    check("first_period_start_latency", 32'(n + 1), 512);

    // Period 1: single write, chan 0 duty 64.
    repeat (5) @(negedge clk);
    wr(3'd0, 8'd64);
    check("err_on_valid_write", 32'(o_err), 0);
    v_exp[0] = 8'd64;
    exp_q.push_back(v_exp);
    wait_ps(n);
    check("period_length", 32'(n + 6), 512);

    // Period 2: extremes, plus last-write-wins on chan 1.
    wr(3'd1, 8'd200);
    wr(3'd1, 8'd0);
    wr(3'd2, 8'd255);
    v_exp[2] = 8'd255;
    exp_q.push_back(v_exp);
    wait_ps(n);

    // Period 3: out-of-range channels are dropped with a one-cycle error pulse.
    repeat (20) @(negedge clk);
    wr(3'd6, 8'd33);
    check("err_chan6", 32'(o_err), 1);
    @(negedge clk);
    check("err_chan6_clears", 32'(o_err), 0);
    wr(3'd7, 8'd99);
    check("err_chan7", 32'(o_err), 1);
    @(negedge clk);
    check("err_chan7_clears", 32'(o_err), 0);
    exp_q.push_back(v_exp);
    wait_ps(n);

    // Period 4: mid-period write at pwm_cnt=50, then a write in the commit cycle.
    repeat (100) @(negedge clk);
    wr(3'd3, 8'd128);
    v_exp[3] = 8'd128;
    v_exp[4] = 8'd10;
    exp_q.push_back(v_exp);
    repeat (410) @(negedge clk);
    check("no_period_start_before_commit", 32'(o_period_start), 0);
    wr(3'd4, 8'd10);
    check("period_start_after_commit_write", 32'(o_period_start), 1);

    // Period 5: reset at pwm_cnt=100 aborts the period and clears all duties.
    repeat (200) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check("midrst_led", 32'(o_led), 32'h3f);
    check("midrst_ready", 32'(o_ready), 0);
    check("midrst_period_start", 32'(o_period_start), 0);
    @(negedge clk);
    check("midrst_led_hold", 32'(o_led), 32'h3f);
    v_exp = '0;
    exp_q.push_back(v_exp);
    i_reset = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", 32'(o_ready), 1);
    check("led_off_after_midrst", 32'(o_led), 32'h3f);
    wait_ps(n);
    check("period_start_latency_after_midrst", 32'(n + 1), 512);

    // Duties stay cleared until a fresh write arrives.
    repeat (10) @(negedge clk);
    wr(3'd5, 8'd255);
    v_exp[5] = 8'd255;
    exp_q.push_back(v_exp);
    wait_ps(n);
    wait_ps(n);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    check("windows_scored", 32'(windows_done), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
